// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - decode-to-execute pipeline register bus
interface id_ex_if;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;
    logic        valid_o;
    logic        ready_i;

    modport slave (
        input  inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i, valid_i, flush_i, ready_i,
        output inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o, valid_o, ready_o
    );

    modport master (
        output inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i, valid_i, flush_i, ready_i,
        input  inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o, valid_o, ready_o
    );
endinterface

// File: rtl/id_ex.sv
// rtl/id_ex.sv - ID/EX pipeline register; ID_EX_SKID_EN selects a 2-entry skid buffer
module id_ex #(
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter logic [31:0] BUBBLE_ADDR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    id_ex_if.slave     bus
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } payload_t;

    localparam payload_t BUBBLE = payload_t'({NOP_INST, BUBBLE_ADDR, 32'd0, 32'd0, 5'd0, 1'b0});

    payload_t main_q, main_d;
    logic     main_valid_q, main_valid_d;
    payload_t in_pl;
    logic     drain;
    logic     accept;
    logic     ready;

    assign in_pl  = payload_t'({bus.inst_i, bus.inst_addr_i, bus.op1_i, bus.op2_i,
                                bus.rd_addr_i, bus.reg_wen_i});
    // Main entry is free to reload when empty or when execute consumes it this edge.
    assign drain  = !main_valid_q || bus.ready_i;
    assign accept = bus.valid_i && ready && !bus.flush_i;

`ifdef ID_EX_SKID_EN
    payload_t skid_q, skid_d;
    logic     skid_valid_q, skid_valid_d;

    // Registered ready: the only thing that can refuse input is an occupied skid entry.
    assign ready = !skid_valid_q;
`else
    // Single entry: accept whenever the held payload leaves this edge or nothing is held.
    assign ready = bus.ready_i || !main_valid_q;
`endif

    // Next-state: flush wins, then reload main (skid first, then input), else park input in skid.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
`ifdef ID_EX_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
`endif
        if (bus.flush_i) begin
            main_d       = BUBBLE;
            main_valid_d = 1'b0;
`ifdef ID_EX_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else if (drain) begin
`ifdef ID_EX_SKID_EN
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else
`endif
            if (accept) begin
                main_d       = in_pl;
                main_valid_d = 1'b1;
            end else begin
                main_d       = BUBBLE;
                main_valid_d = 1'b0;
            end
        end
`ifdef ID_EX_SKID_EN
        else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
`endif
    end

    // State registers; reset empties every entry and presents the bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= BUBBLE;
            main_valid_q <= 1'b0;
`ifdef ID_EX_SKID_EN
            skid_q       <= BUBBLE;
            skid_valid_q <= 1'b0;
`endif
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
`ifdef ID_EX_SKID_EN
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
`endif
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = main_valid_q;
    assign bus.inst_o      = main_q.inst;
    assign bus.inst_addr_o = main_q.addr;
    assign bus.op1_o       = main_q.op1;
    assign bus.op2_o       = main_q.op2;
    assign bus.rd_addr_o   = main_q.rd;
    assign bus.reg_wen_o   = main_q.wen;

endmodule

// File: tb/tb_id_ex.sv
// tb/tb_id_ex.sv - self-checking bench for id_ex (either buffering variant)
module tb_id_ex;

    typedef logic [133:0] pl_t;

    typedef struct {
        logic rst_n;
        logic valid;
        logic flush;
        pl_t  pl;
        logic exp_valid;
        pl_t  exp_pl;
    } vec_t;

    localparam pl_t BUBBLE = {32'h0000_0013, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    pl_t  model_q[$];
    int   out_fires;

    id_ex_if bus ();

    id_ex dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic pl_t dut_pl();
        return {bus.inst_o, bus.inst_addr_o, bus.op1_o, bus.op2_o, bus.rd_addr_o, bus.reg_wen_o};
    endfunction

    function automatic pl_t rand_pl();
        return {$urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom)};
    endfunction

    task automatic chk(input string name, input pl_t act, input pl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic rdy, input logic fl, input pl_t p);
        rst_n           = r;
        bus.valid_i     = v;
        bus.ready_i     = rdy;
        bus.flush_i     = fl;
        {bus.inst_i, bus.inst_addr_i, bus.op1_i, bus.op2_i, bus.rd_addr_i, bus.reg_wen_i} = p;
    endtask

    // Expected acceptance readiness from the model's occupancy.
    function automatic logic model_ready(input logic rdy);
`ifdef ID_EX_SKID_EN
        return model_q.size() < 2;
`else
        return (model_q.size() == 0) || rdy;
`endif
    endfunction

    // One clock: drive, check outputs against the queue model, then advance the model.
    task automatic step(input logic r, input logic v, input logic rdy, input logic fl,
                        input pl_t p, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        drive(r, v, rdy, fl, p);
        #1;
        exp_rdy = model_ready(rdy);
        chk("valid_o", pl_t'(bus.valid_o), pl_t'(model_q.size() > 0));
        chk("payload", dut_pl(), (model_q.size() > 0) ? model_q[0] : BUBBLE);
        chk("ready_o", pl_t'(bus.ready_o), pl_t'(exp_rdy));
        if (bus.valid_o && rdy) out_fires++;
        acc = r && !fl && v && exp_rdy;
        @(posedge clk);
        if (!r || fl) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
            if (v && exp_rdy) model_q.push_back(p);
        end
    endtask

    initial begin
        vec_t  vecs[9];
        pl_t   pa, pb, pc, pd, pe, pend;
        logic  acc;
        int    sent, guard;
        logic  rdy_pat[4];

        pa = {32'h0050_0093, 32'h0000_0100, 32'd0, 32'd5, 5'd1, 1'b1};
        pb = {32'h0020_81b3, 32'h0000_0104, 32'd7, 32'd9, 5'd3, 1'b1};
        pc = {32'h0000_0463, 32'h0000_0108, 32'd1, 32'd1, 5'd0, 1'b0};
        pd = {32'h00a0_0113, 32'h0000_0200, 32'd0, 32'd10, 5'd2, 1'b1};
        pe = {32'h0ff0_0193, 32'h0000_0204, 32'd0, 32'd255, 5'd3, 1'b1};

        vecs[0] = '{1'b0, 1'b0, 1'b0, pa, 1'b0, BUBBLE};
        vecs[1] = '{1'b1, 1'b0, 1'b0, pa, 1'b0, BUBBLE};
        vecs[2] = '{1'b1, 1'b1, 1'b0, pa, 1'b1, pa};
        vecs[3] = '{1'b1, 1'b0, 1'b0, pb, 1'b0, BUBBLE};
        vecs[4] = '{1'b1, 1'b1, 1'b0, pb, 1'b1, pb};
        vecs[5] = '{1'b1, 1'b1, 1'b1, pc, 1'b0, BUBBLE};
        vecs[6] = '{1'b1, 1'b0, 1'b0, pc, 1'b0, BUBBLE};
        vecs[7] = '{1'b1, 1'b1, 1'b0, pd, 1'b1, pd};
        vecs[8] = '{1'b0, 1'b1, 1'b0, pe, 1'b0, BUBBLE};

        out_fires = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, BUBBLE);

        // Directed table: ready_i held high, so ready_o must be 1 in both variants.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].valid, 1'b1, vecs[i].flush, vecs[i].pl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), pl_t'(bus.valid_o), pl_t'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_payload", i), dut_pl(), vecs[i].exp_pl);
            chk($sformatf("vec%0d_ready", i), pl_t'(bus.ready_o), pl_t'(1'b1));
        end

        // Eight back-to-back payloads with ready_i 1,0,0,1 repeating; offer held until taken.
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        out_fires = 0;
        sent = 0;
        guard = 0;
        pend = rand_pl();
        while (sent < 8 && guard < 64) begin
            step(1'b1, 1'b1, rdy_pat[guard % 4], 1'b0, pend, acc);
            if (acc) begin
                sent++;
                pend = rand_pl();
            end
            guard++;
        end
        chk("b2b_accepted", pl_t'(sent), pl_t'(8));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, pend, acc);
        chk("b2b_delivered", pl_t'(out_fires), pl_t'(8));

        // Flush while stalled with a new offer in the same cycle.
        step(1'b1, 1'b1, 1'b1, 1'b0, pa, acc);
        step(1'b1, 1'b1, 1'b0, 1'b0, pb, acc);
        step(1'b1, 1'b1, 1'b0, 1'b1, pc, acc);
        step(1'b1, 1'b0, 1'b1, 1'b0, pd, acc);
        step(1'b1, 1'b0, 1'b1, 1'b0, pd, acc);

        // Reset with every entry occupied, then idle after release.
        step(1'b1, 1'b1, 1'b1, 1'b0, pa, acc);
        step(1'b1, 1'b1, 1'b0, 1'b0, pb, acc);
        step(1'b0, 1'b1, 1'b0, 1'b0, pc, acc);
        step(1'b1, 1'b0, 1'b0, 1'b0, pd, acc);
        step(1'b1, 1'b0, 1'b1, 1'b0, pd, acc);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3),
                 rand_pl(), acc);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, BUBBLE, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
